// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO flow-control FSM: sizing defaults, FIFO
// index map, state encoding and per-FIFO pause mode.
package fifo_ctrl_pkg;

  localparam int WIDTH_DEF = 5;  // threshold / fill-level width
  localparam int NFIFO_DEF = 5;  // number of managed FIFOs

  // FIFO index map; fill, empties, errors and pause use these bit positions.
  localparam int FIFO_MAIN = 0;
  localparam int FIFO_VC0  = 1;
  localparam int FIFO_VC1  = 2;
  localparam int FIFO_D0   = 3;
  localparam int FIFO_D1   = 4;

  // One-hot controller states, visible directly on the state output.
  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_e;

  // How a pause flag evolves on the next edge.
  typedef enum logic [1:0] {
    PM_CLEAR = 2'd0,  // forced low (RESET / INIT)
    PM_SET   = 2'd1,  // forced high (ERROR)
    PM_HYST  = 2'd2   // threshold hysteresis (IDLE / ACTIVE)
  } pause_mode_e;

  // Pause behaviour implied by the state the controller is entering.
  function automatic pause_mode_e pause_mode_for(state_e s);
    case (s)
      ST_IDLE, ST_ACTIVE: return PM_HYST;
      ST_ERROR:           return PM_SET;
      default:            return PM_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/pause_hyst.sv
// Per-FIFO pause flag with set/clear hysteresis on the fill level.
module pause_hyst
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,    // synchronous, active-low
  input  pause_mode_e      i_mode,
  input  logic [WIDTH-1:0] i_fill,
  input  logic [WIDTH-1:0] i_low,
  input  logic [WIDTH-1:0] i_high,
  output logic             o_pause
);

  logic r_pause;

  // Pause register: forced by mode, otherwise set at/above high, clear at/below low.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pause <= 1'b0;
    end else begin
      case (i_mode)
        PM_CLEAR: r_pause <= 1'b0;
        PM_SET:   r_pause <= 1'b1;
        default: begin
          if (i_fill >= i_high)     r_pause <= 1'b1;
          else if (i_fill <= i_low) r_pause <= 1'b0;
        end
      endcase
    end
  end

  assign o_pause = r_pause;

endmodule

// File: rtl/fifo_ctrl_fsm.sv
// FIFO flow-control controller: configuration capture, idle/active tracking,
// sticky error handling and per-FIFO pause with hysteresis. All outputs are
// registered and reflect the state entered on the same edge.
module fifo_ctrl_fsm
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NFIFO = NFIFO_DEF  // named threshold ports assume 5 FIFOs
) (
  input  logic                   clk,
  input  logic                   reset,  // synchronous, active-low
  input  logic                   init,
  input  logic [WIDTH-1:0]       main_fifo_low,
  input  logic [WIDTH-1:0]       main_fifo_high,
  input  logic [WIDTH-1:0]       Vc0_low,
  input  logic [WIDTH-1:0]       Vc0_high,
  input  logic [WIDTH-1:0]       Vc1_low,
  input  logic [WIDTH-1:0]       Vc1_high,
  input  logic [WIDTH-1:0]       D0_low,
  input  logic [WIDTH-1:0]       D0_high,
  input  logic [WIDTH-1:0]       D1_low,
  input  logic [WIDTH-1:0]       D1_high,
  input  logic [NFIFO-1:0]       empties,
  input  logic [NFIFO-1:0]       errors,
  input  logic [NFIFO*WIDTH-1:0] fill,
  output logic [WIDTH-1:0]       main_fifo_low_out,
  output logic [WIDTH-1:0]       main_fifo_high_out,
  output logic [WIDTH-1:0]       Vc0_low_out,
  output logic [WIDTH-1:0]       Vc0_high_out,
  output logic [WIDTH-1:0]       Vc1_low_out,
  output logic [WIDTH-1:0]       Vc1_high_out,
  output logic [WIDTH-1:0]       D0_low_out,
  output logic [WIDTH-1:0]       D0_high_out,
  output logic [WIDTH-1:0]       D1_low_out,
  output logic [WIDTH-1:0]       D1_high_out,
  output logic [4:0]             state,
  output logic [NFIFO-1:0]       pause,
  output logic                   idle_out,
  output logic                   error_out,
  output logic                   cfg_err,
  output logic [NFIFO-1:0]       error_latched
);

  state_e           r_state;
  logic             r_idle_out;
  logic             r_error_out;
  logic             r_cfg_err;
  logic [NFIFO-1:0] r_error_latched;
  logic [WIDTH-1:0] r_low_out  [NFIFO];
  logic [WIDTH-1:0] r_high_out [NFIFO];

  state_e           w_state_nxt;
  pause_mode_e      w_pause_mode;
  logic             w_cfg_bad;
  logic             w_cfg_fault;
  logic [NFIFO-1:0] w_pause;
  logic [WIDTH-1:0] w_low_in   [NFIFO];
  logic [WIDTH-1:0] w_high_in  [NFIFO];
  logic [WIDTH-1:0] w_low_nxt  [NFIFO];
  logic [WIDTH-1:0] w_high_nxt [NFIFO];

  // Gather the named threshold ports into index-addressed arrays.
  assign w_low_in[FIFO_MAIN]  = main_fifo_low;
  assign w_high_in[FIFO_MAIN] = main_fifo_high;
  assign w_low_in[FIFO_VC0]   = Vc0_low;
  assign w_high_in[FIFO_VC0]  = Vc0_high;
  assign w_low_in[FIFO_VC1]   = Vc1_low;
  assign w_high_in[FIFO_VC1]  = Vc1_high;
  assign w_low_in[FIFO_D0]    = D0_low;
  assign w_high_in[FIFO_D0]   = D0_high;
  assign w_low_in[FIFO_D1]    = D1_low;
  assign w_high_in[FIFO_D1]   = D1_high;

  // Thresholds in effect after this edge: INIT captures the inputs, other states hold.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_cfg_bad = 1'b0;
    for (int i = 0; i < NFIFO; i++) begin
      w_low_nxt[i]  = r_low_out[i];
      w_high_nxt[i] = r_high_out[i];
      if (r_state == ST_INIT) begin
        w_low_nxt[i]  = w_low_in[i];
        w_high_nxt[i] = w_high_in[i];
      end
      if (w_low_in[i] >= w_high_in[i]) w_cfg_bad = 1'b1;
    end
  end

  // Next-state selection; errors always win over init.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RESET: w_state_nxt = ST_INIT;
      ST_INIT: begin
        if (errors != '0)  w_state_nxt = ST_ERROR;
        else if (init)     w_state_nxt = ST_INIT;
        else if (w_cfg_bad) w_state_nxt = ST_ERROR;
        else               w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (errors != '0)    w_state_nxt = ST_ERROR;
        else if (init)       w_state_nxt = ST_INIT;
        else if (!(&empties)) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (errors != '0)  w_state_nxt = ST_ERROR;
        else if (init)     w_state_nxt = ST_INIT;
        else if (&empties) w_state_nxt = ST_IDLE;
      end
      ST_ERROR: w_state_nxt = ST_ERROR;
      default:  w_state_nxt = ST_RESET;  // recover from an illegal encoding
    endcase
  end

  // A configuration fault is the INIT exit to ERROR caused only by low >= high.
  assign w_cfg_fault  = (r_state == ST_INIT) && (errors == '0) && !init && w_cfg_bad;
  assign w_pause_mode = pause_mode_for(w_state_nxt);

  // State register and the status flags that track the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ST_RESET;
      r_idle_out      <= 1'b0;
      r_error_out     <= 1'b0;
      r_cfg_err       <= 1'b0;
      r_error_latched <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idle_out  <= (w_state_nxt == ST_IDLE);
      r_error_out <= (w_state_nxt == ST_ERROR);
      r_cfg_err   <= r_cfg_err | w_cfg_fault;
      if (r_state != ST_RESET) r_error_latched <= r_error_latched | errors;
    end
  end

  // Active threshold registers, loaded while in INIT and held elsewhere.
  // NOTE: these small register arrays are reset explicitly because they drive outputs; a true storage memory would not be.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NFIFO; i++) begin
        r_low_out[i]  <= '0;
        r_high_out[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NFIFO; i++) begin
        r_low_out[i]  <= w_low_nxt[i];
        r_high_out[i] <= w_high_nxt[i];
      end
    end
  end

  // One hysteresis flag per FIFO, compared against the thresholds taking effect.
  for (genvar i = 0; i < NFIFO; i++) begin : g_hyst
    pause_hyst #(.WIDTH(WIDTH)) u_pause_hyst (
      .clk     (clk),
      .reset   (reset),
      .i_mode  (w_pause_mode),
      .i_fill  (fill[i*WIDTH +: WIDTH]),
      .i_low   (w_low_nxt[i]),
      .i_high  (w_high_nxt[i]),
      .o_pause (w_pause[i])
    );
  end

  assign state              = r_state;
  assign pause              = w_pause;
  assign idle_out           = r_idle_out;
  assign error_out          = r_error_out;
  assign cfg_err            = r_cfg_err;
  assign error_latched      = r_error_latched;
  assign main_fifo_low_out  = r_low_out[FIFO_MAIN];
  assign main_fifo_high_out = r_high_out[FIFO_MAIN];
  assign Vc0_low_out        = r_low_out[FIFO_VC0];
  assign Vc0_high_out       = r_high_out[FIFO_VC0];
  assign Vc1_low_out        = r_low_out[FIFO_VC1];
  assign Vc1_high_out       = r_high_out[FIFO_VC1];
  assign D0_low_out         = r_low_out[FIFO_D0];
  assign D0_high_out        = r_high_out[FIFO_D0];
  assign D1_low_out         = r_low_out[FIFO_D1];
  assign D1_high_out        = r_high_out[FIFO_D1];

endmodule

// File: tb/tb_fifo_ctrl_fsm.sv
// Self-checking bench for fifo_ctrl_fsm: table-driven vectors, hand-written
// corner sequences and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_fifo_ctrl_fsm;

  localparam int W = 5;
  localparam int N = 5;

  // Model state names; expected state output is the one-hot 1 << index.
  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic [W-1:0] thr_lo [N];
  logic [W-1:0] thr_hi [N];
  logic [N-1:0] empties;
  logic [N-1:0] errors;
  logic [N*W-1:0] fill;

  logic [W-1:0] lo_out [N];
  logic [W-1:0] hi_out [N];
  logic [4:0]   state;
  logic [N-1:0] pause;
  logic         idle_out, error_out, cfg_err;
  logic [N-1:0] error_latched;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model
  int           m_st;
  logic [W-1:0] m_lo [N];
  logic [W-1:0] m_hi [N];
  logic [N-1:0] m_pause;
  logic [N-1:0] m_elat;
  bit           m_cfg;

  fifo_ctrl_fsm #(.WIDTH(W), .NFIFO(N)) dut (
    .clk(clk), .reset(reset), .init(init),
    .main_fifo_low(thr_lo[0]), .main_fifo_high(thr_hi[0]),
    .Vc0_low(thr_lo[1]), .Vc0_high(thr_hi[1]),
    .Vc1_low(thr_lo[2]), .Vc1_high(thr_hi[2]),
    .D0_low(thr_lo[3]), .D0_high(thr_hi[3]),
    .D1_low(thr_lo[4]), .D1_high(thr_hi[4]),
    .empties(empties), .errors(errors), .fill(fill),
    .main_fifo_low_out(lo_out[0]), .main_fifo_high_out(hi_out[0]),
    .Vc0_low_out(lo_out[1]), .Vc0_high_out(hi_out[1]),
    .Vc1_low_out(lo_out[2]), .Vc1_high_out(hi_out[2]),
    .D0_low_out(lo_out[3]), .D0_high_out(hi_out[3]),
    .D1_low_out(lo_out[4]), .D1_high_out(hi_out[4]),
    .state(state), .pause(pause), .idle_out(idle_out), .error_out(error_out),
    .cfg_err(cfg_err), .error_latched(error_latched)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack_fill(input int f0, f1, f2, f3, f4);
    logic [N*W-1:0] v;
    v = {W'(f4), W'(f3), W'(f2), W'(f1), W'(f0)};
    return v;
  endfunction

  function automatic logic [2*N*W-1:0] pack_thr_out();
    logic [2*N*W-1:0] v = '0;
    for (int i = 0; i < N; i++) v[2*W*i +: 2*W] = {hi_out[i], lo_out[i]};
    return v;
  endfunction

  function automatic logic [2*N*W-1:0] pack_thr_model();
    logic [2*N*W-1:0] v = '0;
    for (int i = 0; i < N; i++) v[2*W*i +: 2*W] = {m_hi[i], m_lo[i]};
    return v;
  endfunction

  function automatic logic [2*N*W-1:0] pack_thr_in();
    logic [2*N*W-1:0] v = '0;
    for (int i = 0; i < N; i++) v[2*W*i +: 2*W] = {thr_hi[i], thr_lo[i]};
    return v;
  endfunction

  function automatic bit any_bad_cfg();
    for (int i = 0; i < N; i++) if (thr_lo[i] >= thr_hi[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int nxt;
    logic [W-1:0] lo_n [N];
    logic [W-1:0] hi_n [N];
    if (!reset) begin
      m_st = M_RESET; m_cfg = 1'b0; m_elat = '0; m_pause = '0;
      for (int i = 0; i < N; i++) begin m_lo[i] = '0; m_hi[i] = '0; end
      return;
    end
    for (int i = 0; i < N; i++) begin
      lo_n[i] = (m_st == M_INIT) ? thr_lo[i] : m_lo[i];
      hi_n[i] = (m_st == M_INIT) ? thr_hi[i] : m_hi[i];
    end
    case (m_st)
      M_RESET: nxt = M_INIT;
      M_ERROR: nxt = M_ERROR;
      default: begin
        if (errors != 0)         nxt = M_ERROR;
        else if (init)           nxt = M_INIT;
        else if (m_st == M_INIT) nxt = any_bad_cfg() ? M_ERROR : M_IDLE;
        else                     nxt = (empties == '1) ? M_IDLE : M_ACTIVE;
      end
    endcase
    if (m_st == M_INIT && nxt == M_ERROR && errors == 0) m_cfg = 1'b1;
    if (m_st != M_RESET) m_elat = m_elat | errors;
    for (int i = 0; i < N; i++) begin
      int f;
      f = int'(fill[i*W +: W]);
      if (nxt == M_ERROR)                      m_pause[i] = 1'b1;
      else if (nxt == M_RESET || nxt == M_INIT) m_pause[i] = 1'b0;
      else if (f >= int'(hi_n[i]))             m_pause[i] = 1'b1;
      else if (f <= int'(lo_n[i]))             m_pause[i] = 1'b0;
    end
    m_st = nxt;
    for (int i = 0; i < N; i++) begin m_lo[i] = lo_n[i]; m_hi[i] = hi_n[i]; end
  endtask

  // One clock: update the model, then sample just after the edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"}, state, 5'b1 << m_st);
    check({tag, ".pause"}, pause, m_pause);
    check({tag, ".idle"}, idle_out, (m_st == M_IDLE));
    check({tag, ".error"}, error_out, (m_st == M_ERROR));
    check({tag, ".cfg_err"}, cfg_err, m_cfg);
    check({tag, ".err_lat"}, error_latched, m_elat);
    check({tag, ".thr"}, pack_thr_out(), pack_thr_model());
  endtask

  task automatic set_default_thr();
    thr_lo[0] = 3;  thr_hi[0] = 6;
    thr_lo[1] = 11; thr_hi[1] = 20;
    thr_lo[2] = 2;  thr_hi[2] = 9;
    thr_lo[3] = 4;  thr_hi[3] = 12;
    thr_lo[4] = 1;  thr_hi[4] = 30;
  endtask

  task automatic go_idle();
    reset = 1'b0; init = 1'b0; errors = '0; empties = '1; fill = '0;
    set_default_thr();
    tick();
    reset = 1'b1;
    tick();
    tick();
  endtask

  typedef struct {
    bit             rst;
    bit             ini;
    logic [N-1:0]   emp;
    logic [N*W-1:0] fil;
    logic [4:0]     e_state;
    logic [N-1:0]   e_pause;
    bit             e_idle;
  } vec_t;

  vec_t vecs [13];

  initial begin
    reset = 1'b0; init = 1'b0; empties = '1; errors = '0; fill = '0;
    set_default_thr();

    // Thresholds: main 3/6, Vc0 11/20, Vc1 2/9, D0 4/12, D1 1/30.
    vecs[0]  = '{0, 0, 5'b11111, pack_fill(0, 0, 0, 0, 0),  5'b00001, 5'b00000, 0};
    vecs[1]  = '{1, 0, 5'b11111, pack_fill(0, 0, 0, 0, 0),  5'b00010, 5'b00000, 0};
    vecs[2]  = '{1, 0, 5'b11111, pack_fill(0, 0, 0, 0, 0),  5'b00100, 5'b00000, 1};
    vecs[3]  = '{1, 0, 5'b11110, pack_fill(2, 0, 0, 0, 0),  5'b01000, 5'b00000, 0};
    vecs[4]  = '{1, 0, 5'b11110, pack_fill(6, 0, 0, 0, 0),  5'b01000, 5'b00001, 0};
    vecs[5]  = '{1, 0, 5'b11110, pack_fill(5, 0, 0, 0, 0),  5'b01000, 5'b00001, 0};
    vecs[6]  = '{1, 0, 5'b11110, pack_fill(3, 0, 0, 0, 0),  5'b01000, 5'b00000, 0};
    vecs[7]  = '{1, 0, 5'b11111, pack_fill(2, 0, 0, 0, 0),  5'b00100, 5'b00000, 1};
    vecs[8]  = '{1, 0, 5'b11111, pack_fill(2, 20, 0, 0, 0), 5'b00100, 5'b00010, 1};
    vecs[9]  = '{1, 1, 5'b11111, pack_fill(2, 15, 0, 0, 0), 5'b00010, 5'b00000, 0};
    vecs[10] = '{1, 0, 5'b11111, pack_fill(2, 15, 0, 0, 0), 5'b00100, 5'b00000, 1};
    vecs[11] = '{1, 0, 5'b11111, pack_fill(2, 11, 0, 0, 30), 5'b00100, 5'b10000, 1};
    vecs[12] = '{1, 0, 5'b11111, pack_fill(2, 11, 0, 0, 1), 5'b00100, 5'b00000, 1};

    @(negedge clk);
    for (int k = 0; k < 13; k++) begin
      reset = vecs[k].rst; init = vecs[k].ini;
      empties = vecs[k].emp; fill = vecs[k].fil; errors = '0;
      tick();
      check($sformatf("vec%0d.state", k), state, vecs[k].e_state);
      check($sformatf("vec%0d.pause", k), pause, vecs[k].e_pause);
      check($sformatf("vec%0d.idle", k), idle_out, vecs[k].e_idle);
      check($sformatf("vec%0d.error", k), error_out, 1'b0);
      if (k == 0) begin
        check("reset.thr", pack_thr_out(), '0);
        check("reset.err_lat", error_latched, '0);
        check("reset.cfg_err", cfg_err, 1'b0);
      end
    end

    // Captured thresholds match the inputs, and hold when inputs change outside INIT.
    check("thr.captured", pack_thr_out(),
          {W'(30), W'(1), W'(12), W'(4), W'(9), W'(2), W'(20), W'(11), W'(6), W'(3)});
    thr_lo[0] = 9; thr_hi[0] = 1;
    tick();
    check("thr.hold", pack_thr_out(),
          {W'(30), W'(1), W'(12), W'(4), W'(9), W'(2), W'(20), W'(11), W'(6), W'(3)});
    check("thr.hold.state", state, 5'b00100);

    // Simultaneous init and errors in IDLE resolve to ERROR, which then absorbs.
    go_idle();
    init = 1'b1; errors = 5'b00100;
    tick();
    check("err_init.state", state, 5'b10000);
    check("err_init.error", error_out, 1'b1);
    check("err_init.pause", pause, 5'b11111);
    check("err_init.err_lat", error_latched, 5'b00100);
    check("err_init.cfg_err", cfg_err, 1'b0);
    errors = '0; init = 1'b1;
    tick();
    check("absorb.state", state, 5'b10000);

    // Single-cycle error in ACTIVE: sticky latch, then reset clears everything.
    go_idle();
    empties = 5'b11110;
    tick();
    check("active.state", state, 5'b01000);
    errors = 5'b00001;
    tick();
    check("act_err.state", state, 5'b10000);
    errors = '0;
    tick();
    tick();
    check("act_err.err_lat", error_latched, 5'b00001);
    check("act_err.pause", pause, 5'b11111);
    reset = 1'b0;
    tick();
    check("rst_err.state", state, 5'b00001);
    check("rst_err.outs", {pause, error_latched, idle_out, error_out, cfg_err}, '0);
    check("rst_err.thr", pack_thr_out(), '0);

    // Misconfigured thresholds seen in INIT flag a configuration error.
    reset = 1'b1; empties = '1;
    thr_lo[2] = 10; thr_hi[2] = 7;
    tick();
    check("cfg.init", state, 5'b00010);
    tick();
    check("cfg.state", state, 5'b10000);
    check("cfg.cfg_err", cfg_err, 1'b1);
    check("cfg.pause", pause, 5'b11111);

    // Randomized run against the model.
    reset = 1'b0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 39) != 0);
      init    = ($urandom_range(0, 9) == 0);
      errors  = ($urandom_range(0, 59) == 0) ? N'($urandom) : '0;
      empties = ($urandom_range(0, 2) == 0) ? '1 : N'($urandom);
      for (int i = 0; i < N; i++) begin
        fill[i*W +: W] = W'($urandom_range(0, 31));
        if ($urandom_range(0, 15) == 0) begin
          thr_lo[i] = W'($urandom); thr_hi[i] = W'($urandom);
        end else begin
          int lo;
          lo = $urandom_range(0, 30);
          thr_lo[i] = W'(lo);
          thr_hi[i] = W'($urandom_range(lo + 1, 31));
        end
      end
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_fsm.md
FIFO_CTRL_FSM -- requirements
Module: fifo_ctrl_fsm

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, as the threshold/fill-level width.
REQ-002 The block SHALL have parameter NFIFO, default 5, as the number of managed FIFOs (index 0 main, 1 Vc0, 2 Vc1, 3 D0, 4 D1).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 init  input  1  request to (re)enter configuration.
REQ-006 main_fifo_low, main_fifo_high, Vc0_low, Vc0_high, Vc1_low, Vc1_high, D0_low, D0_high, D1_low, D1_high  input  WIDTH each  candidate thresholds.
REQ-007 empties  input  NFIFO  per-FIFO empty flags.
REQ-008 errors  input  NFIFO  per-FIFO error flags.
REQ-009 fill  input  NFIFO*WIDTH  per-FIFO occupancy; FIFO i in bits [i*WIDTH +: WIDTH].
REQ-010 <each threshold>_out  output  WIDTH  registered active threshold (10 ports).
REQ-011 state  output  5  one-hot state.
REQ-012 pause  output  NFIFO  per-FIFO flow-control pause.
REQ-013 idle_out, error_out, cfg_err  output  1 each  status flags.
REQ-014 error_latched  output  NFIFO  sticky copy of errors.

Function
REQ-015 States SHALL be RESET=5'b00001, INIT=5'b00010, IDLE=5'b00100, ACTIVE=5'b01000, ERROR=5'b10000.
REQ-016 RESET SHALL go to INIT on the first clock with reset high.
REQ-017 INIT SHALL load all threshold inputs into the *_out registers every cycle it is occupied.
REQ-018 INIT priority: errors!=0 -> ERROR; else init=1 -> INIT; else any input low>=high -> ERROR with cfg_err=1; else -> IDLE.
REQ-019 IDLE priority: errors!=0 -> ERROR; init=1 -> INIT; empties!=all-ones -> ACTIVE; else stay.
REQ-020 ACTIVE priority: errors!=0 -> ERROR; init=1 -> INIT; empties==all-ones -> IDLE; else stay.
REQ-021 ERROR SHALL be absorbing; only reset low exits it.
REQ-022 Threshold outputs SHALL hold their value outside INIT.
REQ-023 error_latched SHALL OR in errors every cycle outside RESET; cleared only by reset.
REQ-024 pause[i] in IDLE/ACTIVE SHALL set when fill_i>=high_out_i, clear when fill_i<=low_out_i, else hold (hysteresis); unsigned WIDTH-bit comparison.
REQ-025 pause SHALL be all-zero in RESET/INIT and all-ones in ERROR.
REQ-026 idle_out=1 exactly in IDLE; error_out=1 exactly in ERROR; all outputs registered, one-cycle latency from input to output.
REQ-027 Simultaneous errors and init SHALL resolve to ERROR.

Reset
REQ-028 With reset low at posedge clk: state=RESET, all thresholds, pause, error_latched, idle_out, error_out, cfg_err = 0.
REQ-029 Reset low in any state, including mid-ACTIVE or ERROR, SHALL take effect at the next edge.

Structure
REQ-030 State encodings, FIFO index constants, WIDTH and NFIFO defaults SHALL live in shared package fifo_ctrl_pkg.
REQ-031 Hysteresis logic SHALL be sub-module pause_hyst (one FIFO, WIDTH param), instantiated NFIFO times.

Verification
REQ-032 Reset low 1 cycle, release, init=0, thresholds main 3/6, Vc0 B/... valid set -> RESET, INIT, IDLE on consecutive edges; *_out equal inputs.
REQ-033 In IDLE, empties=5'b11110 -> ACTIVE next edge; empties=5'b11111 -> IDLE next edge.
REQ-034 main low=3 high=6, fill main 2,6,5,3,2 -> pause[0] 0,1,1,0,0 (one-cycle lag).
REQ-035 INIT with Vc1_low=A, Vc1_high=7 -> ERROR, cfg_err=1, pause=5'b11111.
REQ-036 ACTIVE, errors=5'b00001 for one cycle -> ERROR, error_latched=5'b00001 persists; reset low -> RESET, all outputs 0.
REQ-037 IDLE with init=1 and errors=5'b00100 same cycle -> ERROR, not INIT.
